// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared widths, twiddle constant, lane/twiddle types and index helpers
// for the 8-point inverse FFT pipeline.
package ifft8_pkg;

   localparam int CW_DEF = 4;
   localparam int TW_DEF = 8;

   // round(0.7071 * 2^(tw-1)) in pure integer arithmetic
   function automatic int c707(input int tw);
      return (7071 * (1 << (tw - 1)) + 5000) / 10000;
   endfunction

   localparam int C707 = c707(TW_DEF);

   typedef struct packed {
      logic signed [CW_DEF-1:0] im;
      logic signed [CW_DEF-1:0] re;
   } lane_t;

   typedef enum logic [1:0] {TW_ONE, TW_J, TW_W1, TW_W3} tw_sel_e;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // Maps a conjugate-twiddle exponent (W8^-e) onto the butterfly select.
   function automatic tw_sel_e tw_for(input int e);
      case (e)
         0:       return TW_ONE;
         1:       return TW_W1;
         2:       return TW_J;
         default: return TW_W3;
      endcase
   endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// ifft8_bfly: combinational radix-2 butterfly, top = a + W*b, bottom = a - W*b.
// IFFT_SCALE_EN defined: each output is the CW+1-bit sum shifted right by one (floor).
module ifft8_bfly
   import ifft8_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic [2*CW-1:0] a,
   input  logic [2*CW-1:0] b,
   input  tw_sel_e         tw_sel,
   output logic [2*CW-1:0] top,
   output logic [2*CW-1:0] bot
);
   localparam int PW = CW + TW + 1;
   localparam int CV = c707(TW);

   // W*b as {im, re}, each CW+1 bits so the exact +j rotation keeps -(-2^(CW-1)).
   function automatic logic [2*CW+1:0] twiddle(input logic signed [CW-1:0] br,
                                                input logic signed [CW-1:0] bi,
                                                input tw_sel_e            sel);
      logic signed [PW-1:0] xr, xi, cr, ci, pr, pi;
      logic signed [CW:0]   wr, wi;
      xr = PW'(br);
      xi = PW'(bi);
      cr = PW'(CV);
      ci = PW'(CV);
      if (sel == TW_W3) cr = -cr;
      pr = (xr * cr - xi * ci) >>> (TW - 1);
      pi = (xr * ci + xi * cr) >>> (TW - 1);
      wr = (CW+1)'(signed'(CW'(pr)));
      wi = (CW+1)'(signed'(CW'(pi)));
      case (sel)
         TW_ONE: begin
            wr = (CW+1)'(br);
            wi = (CW+1)'(bi);
         end
         TW_J: begin
            wr = -((CW+1)'(bi));
            wi = (CW+1)'(br);
         end
         default: ;
      endcase
      return {wi, wr};
   endfunction

   function automatic logic [CW-1:0] bf_comp(input logic signed [CW-1:0] ac,
                                             input logic signed [CW:0]   wc,
                                             input logic                 sub);
      logic signed [CW:0] s;
      s = sub ? ((CW+1)'(ac) - wc) : ((CW+1)'(ac) + wc);
`ifdef IFFT_SCALE_EN
      return CW'(s >>> 1);
`else
      return CW'(s);
`endif
   endfunction

   logic [2*CW+1:0] wb;

   assign wb  = twiddle(b[CW-1:0], b[2*CW-1:CW], tw_sel);
   assign top = {bf_comp(a[2*CW-1:CW], wb[2*CW+1:CW+1], 1'b0),
                 bf_comp(a[CW-1:0],    wb[CW:0],        1'b0)};
   assign bot = {bf_comp(a[2*CW-1:CW], wb[2*CW+1:CW+1], 1'b1),
                 bf_comp(a[CW-1:0],    wb[CW:0],        1'b1)};

endmodule

// File: rtl/ifft8_pipeline.sv
// ifft8_pipeline: input register plus three DIT butterfly stages, valid/ready on both sides,
// whole-pipe stall on output backpressure. IFFT_SCALE_EN selects the 1/8-scaled variant.
module ifft8_pipeline
   import ifft8_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [16*CW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [16*CW-1:0] out_data
);
   localparam int LW = 2 * CW;
   localparam int VW = 8 * LW;

   logic          stall;
   logic [VW-1:0] bitrev_vec;
   logic [VW-1:0] data_p0_d, data_p0_q;
   logic [VW-1:0] data_p1_d, data_p1_q;
   logic [VW-1:0] data_p2_d, data_p2_q;
   logic [VW-1:0] data_p3_d, data_p3_q;
   logic          vld_p0_d, vld_p0_q;
   logic          vld_p1_d, vld_p1_q;
   logic          vld_p2_d, vld_p2_q;
   logic          vld_p3_d, vld_p3_q;
   logic [VW-1:0] stage_in  [3];
   logic [VW-1:0] stage_res [3];
   logic [LW-1:0] lane_res  [3][8];

   always_comb begin
      bitrev_vec = '0;
      for (int k = 0; k < 8; k++) begin
         bitrev_vec[int'(bitrev3(3'(k)))*LW +: LW] = in_data[k*LW +: LW];
      end
   end

   assign stage_in[0] = data_p0_q;
   assign stage_in[1] = data_p1_q;
   assign stage_in[2] = data_p2_q;

   // Stage s pairs positions (t, t+2^s) with twiddle W8^-(offset * 4/2^s).
   for (genvar s = 0; s < 3; s++) begin : g_stage
      for (genvar i = 0; i < 4; i++) begin : g_bfly
         localparam int      H    = 1 << s;
         localparam int      OFF  = i % H;
         localparam int      TOP  = (i / H) * 2 * H + OFF;
         localparam tw_sel_e TSEL = tw_for(OFF * (4 / H));

         ifft8_bfly #(.CW(CW), .TW(TW)) u_bfly (
            .a      (stage_in[s][TOP*LW +: LW]),
            .b      (stage_in[s][(TOP+H)*LW +: LW]),
            .tw_sel (TSEL),
            .top    (lane_res[s][TOP]),
            .bot    (lane_res[s][TOP+H])
         );
      end
   end

   always_comb begin
      for (int s = 0; s < 3; s++) begin
         stage_res[s] = '0;
         for (int k = 0; k < 8; k++) begin
            stage_res[s][k*LW +: LW] = lane_res[s][k];
         end
      end
   end

   always_comb begin
      stall     = vld_p3_q & ~out_ready;
      data_p0_d = data_p0_q;
      data_p1_d = data_p1_q;
      data_p2_d = data_p2_q;
      data_p3_d = data_p3_q;
      vld_p0_d  = vld_p0_q;
      vld_p1_d  = vld_p1_q;
      vld_p2_d  = vld_p2_q;
      vld_p3_d  = vld_p3_q;
      if (!stall) begin
         data_p0_d = bitrev_vec;
         vld_p0_d  = in_valid;
         data_p1_d = stage_res[0];
         vld_p1_d  = vld_p0_q;
         data_p2_d = stage_res[1];
         vld_p2_d  = vld_p1_q;
         data_p3_d = stage_res[2];
         vld_p3_d  = vld_p2_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_p0_q <= '0;
         data_p1_q <= '0;
         data_p2_q <= '0;
         data_p3_q <= '0;
         vld_p0_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         vld_p3_q  <= 1'b0;
      end else begin
         // p0: bit-reversed input, p1..p3: outputs of butterfly stages 1..3
         data_p0_q <= data_p0_d;
         data_p1_q <= data_p1_d;
         data_p2_q <= data_p2_d;
         data_p3_q <= data_p3_d;
         vld_p0_q  <= vld_p0_d;
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         vld_p3_q  <= vld_p3_d;
      end
   end

   assign in_ready  = ~stall;
   assign out_valid = vld_p3_q;
   assign out_data  = data_p3_q;

endmodule

// File: tb/tb_ifft8_pipeline.sv
// tb_ifft8_pipeline: directed and randomized checks of ifft8_pipeline against an
// integer IFFT butterfly-network model with a scoreboard queue.
module tb_ifft8_pipeline;
   import ifft8_pkg::*;

   localparam int CW = 4;
   localparam int TW = 8;
   localparam int LW = 2 * CW;
   localparam int VW = 8 * LW;
   localparam int C  = 91;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [VW-1:0] exp_q[$];
   logic [VW-1:0] bv[4];
   logic [VW-1:0] be[4];
   logic          held_v;
   logic [VW-1:0] held_d;
   logic [VW-1:0] tmp;

   ifft8_pipeline #(.CW(CW), .TW(TW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int brev(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   function automatic int fdiv(input int v, input int d);
      int q;
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int wrap(input int v);
      int m;
      m = ((v % 16) + 16) % 16;
      return (m >= 8) ? m - 16 : m;
   endfunction

   function automatic int fin(input int s);
`ifdef IFFT_SCALE_EN
      return wrap(fdiv(s, 2));
`else
      return wrap(s);
`endif
   endfunction

   // Product of b with W8^-e: e=0 -> 1, e=1 -> C+jC, e=2 -> +j, e=3 -> -C+jC.
   function automatic int rot_re(input int br, input int bi, input int e);
      case (e)
         0:       return br;
         2:       return -bi;
         1:       return wrap(fdiv(br * C - bi * C, 1 << (TW - 1)));
         default: return wrap(fdiv(-br * C - bi * C, 1 << (TW - 1)));
      endcase
   endfunction

   function automatic int rot_im(input int br, input int bi, input int e);
      case (e)
         0:       return bi;
         2:       return br;
         1:       return wrap(fdiv(br * C + bi * C, 1 << (TW - 1)));
         default: return wrap(fdiv(br * C - bi * C, 1 << (TW - 1)));
      endcase
   endfunction

   function automatic logic [VW-1:0] ref_ifft(input logic [VW-1:0] x);
      int            re[8], im[8], nr[8], ni[8];
      int            e, wr, wi;
      lane_t         ln;
      logic [VW-1:0] y;
      for (int k = 0; k < 8; k++) begin
         ln = x[k*LW +: LW];
         re[brev(k)] = int'(ln.re);
         im[brev(k)] = int'(ln.im);
      end
      for (int h = 1; h < 8; h = h * 2) begin
         for (int t = 0; t < 8; t++) begin
            if ((t & h) == 0) begin
               e  = (t % h) * (4 / h);
               wr = rot_re(re[t+h], im[t+h], e);
               wi = rot_im(re[t+h], im[t+h], e);
               nr[t]   = fin(re[t] + wr);
               ni[t]   = fin(im[t] + wi);
               nr[t+h] = fin(re[t] - wr);
               ni[t+h] = fin(im[t] - wi);
            end
         end
         re = nr;
         im = ni;
      end
      y = '0;
      for (int n = 0; n < 8; n++) begin
         ln.re = CW'(re[n]);
         ln.im = CW'(im[n]);
         y[n*LW +: LW] = ln;
      end
      return y;
   endfunction

   // Call between a posedge and the next negedge: accepts at the following posedge.
   task automatic run_one(input string tag, input logic [VW-1:0] d, input logic [VW-1:0] e);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      #1;
      check1({tag, "_in_ready"}, in_ready, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check1({tag, "_early_valid"}, out_valid, 1'b0);
      end
      @(negedge clk);
      check1({tag, "_valid_lat3"}, out_valid, 1'b1);
      check64({tag, "_data"}, out_data, e);
      @(negedge clk);
      check1({tag, "_valid_gone"}, out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      held_v    = 1'b0;
      held_d    = '0;
      #1;
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check64("rst_out_data", out_data, 64'h0);
      @(posedge clk);
      #1 reset = 1'b0;

`ifdef IFFT_SCALE_EN
      run_one("scale_all02", 64'h0202020202020202, 64'h0000000000000002);
`else
      run_one("x2_only", 64'h0000000000010000, 64'hF00F1001F00F1001);
      run_one("all01", 64'h0101010101010101, 64'h0000000000000008);
`endif
      tmp = {$urandom, $urandom};
      run_one("rand_single", tmp, ref_ifft(tmp));

      // Backpressure: four back-to-back vectors, output held for five cycles.
      for (int i = 0; i < 4; i++) begin
         bv[i] = {$urandom, $urandom};
         be[i] = ref_ifft(bv[i]);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = bv[i];
         out_ready = 1'b1;
         #1;
         check1("bp_in_ready", in_ready, 1'b1);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         check1("bp_stall_in_ready", in_ready, 1'b0);
         check1("bp_stall_valid", out_valid, 1'b1);
         check64("bp_stall_data", out_data, be[0]);
      end
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check1("bp_drain_valid", out_valid, 1'b1);
         check64("bp_drain_data", out_data, be[i]);
      end
      @(negedge clk);
      check1("bp_after_valid", out_valid, 1'b0);

      // Reset with three vectors in flight.
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check1("rstmid_pre_valid", out_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      check1("rstmid_valid", out_valid, 1'b0);
      check1("rstmid_in_ready", in_ready, 1'b1);
      check64("rstmid_data", out_data, 64'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      tmp = {$urandom, $urandom};
      run_one("rstmid_new", tmp, ref_ifft(tmp));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check1("rstmid_no_ghost", out_valid, 1'b0);
      end

      // Randomized accept/stall traffic against the scoreboard.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (held_v) begin
            check1("hold_valid", out_valid, 1'b1);
            check64("hold_data", out_data, held_d);
         end
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_data   = {$urandom, $urandom};
         #1;
         check1("rand_in_ready", in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check1("rand_extra_out", 1'b1, 1'b0);
            else check64("rand_data", out_data, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(ref_ifft(in_data));
         held_v = out_valid && !out_ready;
         held_d = out_data;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (out_valid) check64("drain_data", out_data, exp_q.pop_front());
      end
      check64("drain_left", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
